// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, FSM states
// and the datapath mux/ALU control encodings.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_IMMEX  = 4'd10,
      S_IMMWB  = 4'd11,
      S_JUMP   = 4'd12,
      S_TRAP   = 4'd13
   } ctrl_state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state function of the multicycle control FSM.
module mc_next_state
   import mips_ctrl_pkg::*;
#(
   parameter int OPW    = 6,
   parameter bit EXT_EN = 1'b1
) (
   input  ctrl_state_t    state,
   input  logic [OPW-1:0] op,
   input  logic           mem_ready,
   output ctrl_state_t    state_next
);

   // NOTE: a default assignment ahead of the case keeps this block free of latches.
   always_comb begin
      state_next = S_RST;
      case (state)
         S_RST:    state_next = S_FETCH;
         S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (op == OP_LW || op == OP_SW)                   state_next = S_MEMADR;
            else if (op == OP_RTYPE)                          state_next = S_EXEC;
            else if (op == OP_BEQ || (EXT_EN && op == OP_BNE)) state_next = S_BRANCH;
            else if (op == OP_ADDI || (EXT_EN && op == OP_ORI)) state_next = S_IMMEX;
            else if (op == OP_J)                              state_next = S_JUMP;
            else                                              state_next = S_TRAP;
         end
         S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_next = S_FETCH;
         S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_next = S_ALUWB;
         S_ALUWB:  state_next = S_FETCH;
         S_BRANCH: state_next = S_FETCH;
         S_IMMEX:  state_next = S_IMMWB;
         S_IMMWB:  state_next = S_FETCH;
         S_JUMP:   state_next = S_FETCH;
         S_TRAP:   state_next = S_TRAP;
         default:  state_next = S_RST;   // unused encodings recover through RST
      endcase
   end

endmodule

// File: rtl/multicycle_maindec.sv
// Main control FSM of the multicycle MIPS datapath: state register plus
// Moore output decode, with mem_ready qualifying the memory-completion strobes.
module multicycle_maindec
   import mips_ctrl_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int ALUOPW = 2,
   parameter bit EXT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [OPW-1:0]    op,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              memwrite,
   output logic              iord,
   output logic              irwrite,
   output logic              pcwrite,
   output logic              branch,
   output logic              branch_ne,
   output logic              regwrite,
   output logic              regdst,
   output logic              memtoreg,
   output logic              alusrca,
   output logic [1:0]        alusrcb,
   output logic [1:0]        pcsrc,
   output logic [ALUOPW-1:0] aluop,
   output logic              illegal_op,
   output logic              retire,
   output logic [3:0]        state_o
);

   ctrl_state_t state, state_next;

   mc_next_state #(
      .OPW    (OPW),
      .EXT_EN (EXT_EN)
   ) u_next_state (
      .state      (state),
      .op         (op),
      .mem_ready  (mem_ready),
      .state_next (state_next)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_RST;
      else          state <= state_next;
   end

   assign state_o = state;

   always_comb begin
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_B;
      pcsrc      = PCSRC_ALU;
      aluop      = ALUOPW'(ALUOP_ADD);
      illegal_op = 1'b0;
      retire     = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = SRCB_FOUR;
            irwrite = mem_ready;
            pcwrite = mem_ready;
         end
         S_DECODE: alusrcb = SRCB_IMM_SH2;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            retire   = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            memwrite = 1'b1;
            iord     = 1'b1;
            retire   = mem_ready;   // the store completes when memory accepts it
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = ALUOPW'(ALUOP_FUNCT);
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            retire   = 1'b1;
         end
         S_BRANCH: begin
            alusrca   = 1'b1;
            aluop     = ALUOPW'(ALUOP_SUB);
            pcsrc     = PCSRC_ALUOUT;
            branch    = (op == OP_BEQ);
            branch_ne = EXT_EN && (op == OP_BNE);
            retire    = 1'b1;
         end
         S_IMMEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluop   = (EXT_EN && op == OP_ORI) ? ALUOPW'(ALUOP_OR) : ALUOPW'(ALUOP_ADD);
         end
         S_IMMWB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
         end
         S_JUMP: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
            retire  = 1'b1;
         end
         S_TRAP:  illegal_op = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Scoreboard bench for multicycle_maindec: directed per-cycle vectors push the
// expected state/outputs; a negedge monitor pops and compares.
module tb_multicycle_maindec;

   // Output word bit order (MSB..LSB):
   // mem_req memwrite iord irwrite pcwrite branch branch_ne regwrite regdst memtoreg
   // alusrca alusrcb[2] pcsrc[2] aluop[2] illegal_op retire
   localparam logic [18:0] O_RST     = 19'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [18:0] O_FWAIT   = 19'b1_0_0_0_0_0_0_0_0_0_0_01_00_00_0_0;
   localparam logic [18:0] O_FGO     = 19'b1_0_0_1_1_0_0_0_0_0_0_01_00_00_0_0;
   localparam logic [18:0] O_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
   localparam logic [18:0] O_MEMADR  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [18:0] O_MEMRD   = 19'b1_0_1_0_0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [18:0] O_MEMWB   = 19'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
   localparam logic [18:0] O_WRWAIT  = 19'b1_1_1_0_0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [18:0] O_WRGO    = 19'b1_1_1_0_0_0_0_0_0_0_0_00_00_00_0_1;
   localparam logic [18:0] O_EXEC    = 19'b0_0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
   localparam logic [18:0] O_ALUWB   = 19'b0_0_0_0_0_0_0_1_1_0_0_00_00_00_0_1;
   localparam logic [18:0] O_BEQ     = 19'b0_0_0_0_0_1_0_0_0_0_1_00_01_01_0_1;
   localparam logic [18:0] O_BNE     = 19'b0_0_0_0_0_0_1_0_0_0_1_00_01_01_0_1;
   localparam logic [18:0] O_IMMADD  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [18:0] O_IMMOR   = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_11_0_0;
   localparam logic [18:0] O_IMMWB   = 19'b0_0_0_0_0_0_0_1_0_0_0_00_00_00_0_1;
   localparam logic [18:0] O_JUMP    = 19'b0_0_0_0_1_0_0_0_0_0_0_00_10_00_0_1;
   localparam logic [18:0] O_TRAP    = 19'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_1_0;

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
   localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101, JMP = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   typedef struct {
      int          vec;
      bit          sel;   // 1: EXT_EN=1 instance, 0: EXT_EN=0 instance
      logic [3:0]  st;
      logic [18:0] ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic       mem_ready;

   logic       mem_req1, memwrite1, iord1, irwrite1, pcwrite1, branch1, branch_ne1;
   logic       regwrite1, regdst1, memtoreg1, alusrca1, illegal_op1, retire1;
   logic [1:0] alusrcb1, pcsrc1, aluop1;
   logic [3:0] state1;
   logic       mem_req0, memwrite0, iord0, irwrite0, pcwrite0, branch0, branch_ne0;
   logic       regwrite0, regdst0, memtoreg0, alusrca0, illegal_op0, retire0;
   logic [1:0] alusrcb0, pcsrc0, aluop0;
   logic [3:0] state0;

   logic [18:0] obs1, obs0;
   assign obs1 = {mem_req1, memwrite1, iord1, irwrite1, pcwrite1, branch1, branch_ne1, regwrite1,
                  regdst1, memtoreg1, alusrca1, alusrcb1, pcsrc1, aluop1, illegal_op1, retire1};
   assign obs0 = {mem_req0, memwrite0, iord0, irwrite0, pcwrite0, branch0, branch_ne0, regwrite0,
                  regdst0, memtoreg0, alusrca0, alusrcb0, pcsrc0, aluop0, illegal_op0, retire0};

   multicycle_maindec #(.OPW(6), .ALUOPW(2), .EXT_EN(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
      .mem_req(mem_req1), .memwrite(memwrite1), .iord(iord1), .irwrite(irwrite1),
      .pcwrite(pcwrite1), .branch(branch1), .branch_ne(branch_ne1), .regwrite(regwrite1),
      .regdst(regdst1), .memtoreg(memtoreg1), .alusrca(alusrca1), .alusrcb(alusrcb1),
      .pcsrc(pcsrc1), .aluop(aluop1), .illegal_op(illegal_op1), .retire(retire1),
      .state_o(state1)
   );

   multicycle_maindec #(.OPW(6), .ALUOPW(2), .EXT_EN(1'b0)) dut_noext (
      .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
      .mem_req(mem_req0), .memwrite(memwrite0), .iord(iord0), .irwrite(irwrite0),
      .pcwrite(pcwrite0), .branch(branch0), .branch_ne(branch_ne0), .regwrite(regwrite0),
      .regdst(regdst0), .memtoreg(memtoreg0), .alusrca(alusrca0), .alusrcb(alusrcb0),
      .pcsrc(pcsrc0), .aluop(aluop0), .illegal_op(illegal_op0), .retire(retire0),
      .state_o(state0)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   vec_cnt  = 0;

   task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got state=%0d outputs=%b, expected state=%0d outputs=%b",
                  name, act[22:19], act[18:0], exp[22:19], exp[18:0]);
      end
   endtask

   // Monitor: sample at the falling edge, far from the rising edge where state moves.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         if (e.sel) check($sformatf("vec%0d", e.vec), {state1, obs1}, {e.st, e.ov});
         else       check($sformatf("vec%0d_noext", e.vec), {state0, obs0}, {e.st, e.ov});
      end
   end

   // One clock cycle of stimulus; the pushed record is what the DUT should show this cycle.
   task automatic step(input logic rn, input logic [5:0] o, input logic mr, input bit sel,
                       input logic [3:0] st, input logic [18:0] ov);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n   = rn;
      op        = o;
      mem_ready = mr;
      e.vec = vec_cnt;
      e.sel = sel;
      e.st  = st;
      e.ov  = ov;
      sb.push_back(e);
      vec_cnt++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n   = 1'b0;
      op        = RT;
      mem_ready = 1'b1;

      // Reset, then RTYPE with no memory wait: 0,1,2,7,8,1
      step(0, RT, 1, 1, 4'd0, O_RST);
      step(1, RT, 1, 1, 4'd0, O_RST);
      step(1, RT, 1, 1, 4'd1, O_FGO);
      step(1, RT, 1, 1, 4'd2, O_DECODE);
      step(1, RT, 1, 1, 4'd7, O_EXEC);
      step(1, RT, 1, 1, 4'd8, O_ALUWB);

      // LW: two FETCH waits, one MEMRD wait; mem_ready in DECODE/MEMADR ignored
      step(1, LW, 0, 1, 4'd1, O_FWAIT);
      step(1, LW, 0, 1, 4'd1, O_FWAIT);
      step(1, LW, 1, 1, 4'd1, O_FGO);
      step(1, LW, 0, 1, 4'd2, O_DECODE);
      step(1, LW, 1, 1, 4'd3, O_MEMADR);
      step(1, LW, 0, 1, 4'd4, O_MEMRD);
      step(1, LW, 1, 1, 4'd4, O_MEMRD);
      step(1, LW, 0, 1, 4'd5, O_MEMWB);

      // SW, no wait: retire in the MEMWR cycle
      step(1, SW, 1, 1, 4'd1, O_FGO);
      step(1, SW, 1, 1, 4'd2, O_DECODE);
      step(1, SW, 1, 1, 4'd3, O_MEMADR);
      step(1, SW, 1, 1, 4'd6, O_WRGO);

      // BEQ, BNE, ORI, ADDI, J
      step(1, BEQ, 1, 1, 4'd1, O_FGO);
      step(1, BEQ, 1, 1, 4'd2, O_DECODE);
      step(1, BEQ, 1, 1, 4'd9, O_BEQ);
      step(1, BNE, 1, 1, 4'd1, O_FGO);
      step(1, BNE, 1, 1, 4'd2, O_DECODE);
      step(1, BNE, 1, 1, 4'd9, O_BNE);
      step(1, ORI, 1, 1, 4'd1, O_FGO);
      step(1, ORI, 1, 1, 4'd2, O_DECODE);
      step(1, ORI, 1, 1, 4'd10, O_IMMOR);
      step(1, ORI, 1, 1, 4'd11, O_IMMWB);
      step(1, ADDI, 1, 1, 4'd1, O_FGO);
      step(1, ADDI, 1, 1, 4'd2, O_DECODE);
      step(1, ADDI, 1, 1, 4'd10, O_IMMADD);
      step(1, ADDI, 1, 1, 4'd11, O_IMMWB);
      step(1, JMP, 1, 1, 4'd1, O_FGO);
      step(1, JMP, 1, 1, 4'd2, O_DECODE);
      step(1, JMP, 1, 1, 4'd12, O_JUMP);

      // SW with one wait cycle in MEMWR: no retire until mem_ready
      step(1, SW, 1, 1, 4'd1, O_FGO);
      step(1, SW, 1, 1, 4'd2, O_DECODE);
      step(1, SW, 1, 1, 4'd3, O_MEMADR);
      step(1, SW, 0, 1, 4'd6, O_WRWAIT);
      step(1, SW, 1, 1, 4'd6, O_WRGO);

      // Illegal opcode: TRAP is sticky regardless of inputs
      step(1, BAD, 1, 1, 4'd1, O_FGO);
      step(1, BAD, 1, 1, 4'd2, O_DECODE);
      step(1, BAD, 1, 1, 4'd13, O_TRAP);
      step(1, RT, 1, 1, 4'd13, O_TRAP);
      step(1, LW, 0, 1, 4'd13, O_TRAP);

      // Reset leaves TRAP; then async reset in the middle of MEMRD
      step(0, RT, 1, 1, 4'd0, O_RST);
      step(1, LW, 1, 1, 4'd0, O_RST);
      step(1, LW, 1, 1, 4'd1, O_FGO);
      step(1, LW, 1, 1, 4'd2, O_DECODE);
      step(1, LW, 1, 1, 4'd3, O_MEMADR);
      step(1, LW, 0, 1, 4'd4, O_MEMRD);
      step(0, LW, 1, 1, 4'd0, O_RST);
      step(1, RT, 1, 1, 4'd0, O_RST);
      step(1, RT, 1, 1, 4'd1, O_FGO);
      step(1, RT, 1, 1, 4'd2, O_DECODE);

      // EXT_EN=0 instance: BNE and ORI are illegal
      step(0, BNE, 1, 0, 4'd0, O_RST);
      step(1, BNE, 1, 0, 4'd0, O_RST);
      step(1, BNE, 1, 0, 4'd1, O_FGO);
      step(1, BNE, 1, 0, 4'd2, O_DECODE);
      step(1, BNE, 1, 0, 4'd13, O_TRAP);
      step(1, BEQ, 1, 0, 4'd13, O_TRAP);
      step(0, ORI, 1, 0, 4'd0, O_RST);
      step(1, ORI, 1, 0, 4'd0, O_RST);
      step(1, ORI, 1, 0, 4'd1, O_FGO);
      step(1, ORI, 1, 0, 4'd2, O_DECODE);
      step(1, ORI, 1, 0, 4'd13, O_TRAP);

      // Let the monitor drain the last record, bounded to a few cycles
      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d records left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_maindec.md
Name: multicycle_maindec

Overview:
- Main control FSM for the multicycle MIPS datapath; next generation of the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Adds a variable-latency memory handshake (mem_req/mem_ready), optional ORI/BNE support, an illegal-opcode trap and a retire pulse.
- Sits between the instruction register opcode field and the datapath/ALU decoder.

Parameters:
- OPW, 6, opcode width.
- ALUOPW, 2, aluop width to the ALU decoder.
- EXT_EN, 1, when 1 decode ORI (6'b001101) and BNE (6'b000101); when 0 these are illegal.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  OPW  opcode from instruction register.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access requested.
- memwrite  out  1  write strobe, valid with mem_req.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  load instruction register.
- pcwrite  out  1  unconditional PC write.
- branch  out  1  PC write if zero.
- branch_ne  out  1  PC write if not zero.
- regwrite  out  1  register-file write.
- regdst  out  1  write register: 1 = rd, 0 = rt.
- memtoreg  out  1  writeback data: 1 = Data register, 0 = ALUOut.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- aluop  out  ALUOPW  00 = add, 01 = sub, 10 = funct, 11 = or.
- illegal_op  out  1  high while in TRAP.
- retire  out  1  one-cycle pulse when an instruction completes.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- States and encodings: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, IMMEX=10, IMMWB=11, JUMP=12, TRAP=13.
- Reset: reset_n low forces state RST immediately. In RST every output is 0 and state_o = 0. The first clock edge after release moves to FETCH. Reset mid-instruction abandons the instruction; no retire.
- Outputs are Moore decodes of state. Exceptions: irwrite/pcwrite in FETCH and retire in MEMWR are qualified by mem_ready (Mealy). Any output not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - mem_ready=0: hold; irwrite=pcwrite=0.
  - mem_ready=1: irwrite=pcwrite=1; go to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - LW (100011) or SW (101011) -> MEMADR.
  - RTYPE (000000) -> EXEC.
  - BEQ (000100), or BNE when EXT_EN -> BRANCH.
  - ADDI (001000), or ORI when EXT_EN -> IMMEX.
  - J (000010) -> JUMP.
  - Anything else -> TRAP.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD; SW -> MEMWR. The opcode is sampled from the stable IR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, retire=1; -> FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. Hold until mem_ready; retire=1 in the mem_ready cycle, then -> FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10; -> ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, retire=1; -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01. branch=1 for BEQ, branch_ne=1 for BNE. retire=1; -> FETCH.
- IMMEX: alusrca=1, alusrcb=10, aluop=00 for ADDI, 11 for ORI; -> IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0, retire=1; -> FETCH.
- JUMP: pcsrc=10, pcwrite=1, retire=1; -> FETCH.
- TRAP: illegal_op=1, all other outputs 0; sticky until reset_n low.
- Latency with zero memory wait:
  - LW: 5 cycles.
  - SW, RTYPE, ADDI, ORI: 4 cycles.
  - BEQ, BNE, J: 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Unused state encodings (14, 15) -> RST on the next edge, outputs all 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J.
  - state enum ctrl_state_t.
  - aluop constants.
  - alusrcb and pcsrc encodings.
- One natural sub-module: mc_next_state, a combinational next-state function of (state, op, mem_ready). Output decode stays in the top.

Test Plan:
- Release reset with op=000000, mem_ready=1 -> state_o 0,1,2,7,8,1. regwrite=regdst=1 in ALUWB. retire pulses once.
- LW (100011) with mem_ready low 2 cycles in FETCH and 1 in MEMRD -> 8 cycles FETCH->FETCH. irwrite high exactly once. memtoreg=1 in MEMWB.
- SW (101011), mem_ready=1 -> MEMWR has mem_req=memwrite=iord=1. retire in the same cycle. Back to FETCH after 4 cycles.
- BNE (000101): EXT_EN=1 -> branch_ne=1, aluop=01, pcsrc=01. EXT_EN=0 -> state_o=13, illegal_op=1, stays until reset.
- op=111111 -> TRAP. Pulse reset_n low mid-MEMRD -> state_o=0 asynchronously, outputs 0, FETCH on the next edge.
- ORI (001101) -> IMMEX aluop=11, IMMWB regwrite=1, regdst=0. J (000010) -> pcsrc=10, pcwrite=1 in JUMP.
